// File: rtl/ysyx_sram_sp_64x128.sv
// Single-port synchronous SRAM model, 64 x 128, active-low CEN/WEN, registered Q.
// Optional build macro: SRAM_WRITE_THROUGH_EN (Q <= D on write cycles).
module ysyx_sram_sp_64x128 #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CEN,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_en;
    logic rd_en;

    assign wr_en = !RST && !CEN && !WEN;
    assign rd_en = !RST && !CEN &&  WEN;

    // Array has no reset so it maps onto a plain RAM; reset only masks the write.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[A] <= D;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= '0;
        end else if (rd_en) begin
            Q <= mem[A];
        end else if (wr_en) begin
`ifdef SRAM_WRITE_THROUGH_EN
            Q <= D;
`else
            Q <= Q;
`endif
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        assert (!$isunknown(CEN))
            else $error("ysyx_sram_sp_64x128: X/Z on CEN");
        if (CEN == 1'b0) begin
            assert (!$isunknown(WEN))
                else $error("ysyx_sram_sp_64x128: X/Z on WEN while CEN=0");
            assert (!$isunknown(A))
                else $error("ysyx_sram_sp_64x128: X/Z on A while CEN=0");
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_sram_sp_64x128.sv
// Self-checking bench for ysyx_sram_sp_64x128: directed scenarios plus a
// randomized run against an array-based reference model.
module tb_ysyx_sram_sp_64x128;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 64;

    logic              clk;
    logic              rst;
    logic              cen;
    logic              wen;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] q;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: word contents, which words hold known data, expected Q.
    logic [DATA_W-1:0] ref_mem   [DEPTH];
    bit                ref_valid [DEPTH];
    logic [DATA_W-1:0] ref_q;
    bit                ref_q_known;

    ysyx_sram_sp_64x128 #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .CEN(cen),
        .WEN(wen),
        .A  (a),
        .D  (d),
        .Q  (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_apply(input logic r, input logic c, input logic w,
                               input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] dd);
        if (r) begin
            ref_q       = '0;
            ref_q_known = 1'b1;
        end else if (!c && w) begin
            ref_q       = ref_mem[ad];
            ref_q_known = ref_valid[ad];
        end else if (!c && !w) begin
            ref_mem[ad]   = dd;
            ref_valid[ad] = 1'b1;
`ifdef SRAM_WRITE_THROUGH_EN
            ref_q       = dd;
            ref_q_known = 1'b1;
`endif
        end
    endtask

    // Apply one cycle of inputs, take the rising edge, sample #1 later.
    task automatic drive(input logic r, input logic c, input logic w,
                         input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] dd);
        rst = r;
        cen = c;
        wen = w;
        a   = ad;
        d   = dd;
        @(posedge clk);
        #1;
        model_apply(r, c, w, ad, dd);
    endtask

    task automatic test_reset;
        logic [DATA_W-1:0] ones;
        ones = '1;
        drive(1'b1, 1'b1, 1'b1, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 6'd5, ones);
        n_tests++;
        if (q !== '0) begin
            n_fail++;
            $display("FAIL reset_q: got %h expected %h", q, {DATA_W{1'b0}});
        end
        drive(1'b0, 1'b0, 1'b1, 6'd5, '0);
        n_tests++;
        if (q === ones) begin
            n_fail++;
            $display("FAIL reset_write_suppressed: got %h expected not %h", q, ones);
        end
    endtask

    task automatic test_write_read;
        logic [DATA_W-1:0] v;
        v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        drive(1'b0, 1'b0, 1'b0, 6'h3F, v);
        drive(1'b0, 1'b0, 1'b1, 6'h3F, '0);
        n_tests++;
        if (q !== v) begin
            n_fail++;
            $display("FAIL write_read: got %h expected %h", q, v);
        end
    endtask

    task automatic test_idle_hold;
        logic [DATA_W-1:0] v;
        v = {DATA_W/8{8'hAA}};
        drive(1'b0, 1'b0, 1'b0, 6'd1, v);
        drive(1'b0, 1'b0, 1'b1, 6'd1, '0);
        n_tests++;
        if (q !== v) begin
            n_fail++;
            $display("FAIL idle_read: got %h expected %h", q, v);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'($urandom), 6'($urandom), {4{32'($urandom)}});
            n_tests++;
            if (q !== v) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: got %h expected %h", i, q, v);
            end
        end
    endtask

    task automatic test_write_no_disturb;
        logic [DATA_W-1:0] v55;
        logic [DATA_W-1:0] v11;
        logic [DATA_W-1:0] exp_q;
        v55 = {DATA_W/8{8'h55}};
        v11 = {DATA_W/8{8'h11}};
        drive(1'b0, 1'b0, 1'b0, 6'd3, v55);
        drive(1'b0, 1'b0, 1'b1, 6'd3, '0);
        drive(1'b0, 1'b0, 1'b0, 6'd2, v11);
`ifdef SRAM_WRITE_THROUGH_EN
        exp_q = v11;
`else
        exp_q = v55;
`endif
        n_tests++;
        if (q !== exp_q) begin
            n_fail++;
            $display("FAIL write_no_disturb: got %h expected %h", q, exp_q);
        end
        drive(1'b0, 1'b0, 1'b1, 6'd2, '0);
        n_tests++;
        if (q !== v11) begin
            n_fail++;
            $display("FAIL write_no_disturb_readback: got %h expected %h", q, v11);
        end
    endtask

    task automatic test_back_to_back;
        logic [DATA_W-1:0] v7;
        logic [DATA_W-1:0] v8;
        v7 = {$urandom, $urandom, $urandom, $urandom};
        v8 = ~v7;
        drive(1'b0, 1'b0, 1'b0, 6'd7, v7);
        drive(1'b0, 1'b0, 1'b0, 6'd8, v8);
        drive(1'b0, 1'b0, 1'b1, 6'd7, '0);
        n_tests++;
        if (q !== v7) begin
            n_fail++;
            $display("FAIL back_to_back_a7: got %h expected %h", q, v7);
        end
        drive(1'b0, 1'b0, 1'b1, 6'd8, '0);
        n_tests++;
        if (q !== v8) begin
            n_fail++;
            $display("FAIL back_to_back_a8: got %h expected %h", q, v8);
        end
    endtask

    task automatic test_full_sweep;
        logic [31:0]       w;
        logic [DATA_W-1:0] exp_q;
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'(i) * 32'h0101_0101;
            drive(1'b0, 1'b0, 1'b0, 6'(i), {4{w}});
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 1'b1, 6'(i), '0);
            w     = 32'(i) * 32'h0101_0101;
            exp_q = {4{w}};
            n_tests++;
            if (q !== exp_q) begin
                n_fail++;
                $display("FAIL full_sweep[%0d]: got %h expected %h", i, q, exp_q);
            end
        end
    endtask

    task automatic test_random;
        logic              r;
        logic              c;
        logic              w;
        logic [ADDR_W-1:0] ad;
        logic [DATA_W-1:0] dd;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            c  = ($urandom_range(0, 3) == 0);
            w  = 1'($urandom);
            ad = 6'($urandom);
            dd = {$urandom, $urandom, $urandom, $urandom};
            drive(r, c, w, ad, dd);
            if (ref_q_known) begin
                n_tests++;
                if (q !== ref_q) begin
                    n_fail++;
                    $display("FAIL random[%0d]: got %h expected %h", i, q, ref_q);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = '0;
            ref_valid[i] = 1'b0;
        end
        ref_q       = '0;
        ref_q_known = 1'b0;
        rst = 1'b1;
        cen = 1'b1;
        wen = 1'b1;
        a   = '0;
        d   = '0;

        test_reset();
        test_write_read();
        test_idle_hold();
        test_write_no_disturb();
        test_back_to_back();
        test_full_sweep();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
